ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave_if.sv | 24 ++
 rtl/ahb_sram_slave.sv | 154 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle for the SRAM slave: address/data-phase signals plus the
// slave response.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: configurable wait states, two-cycle ERROR response,
// byte-lane writes and write-to-read forwarding on back-to-back transfers.
module ahb_sram_slave #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_sram_slave_if.slave   bus
);

  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam int unsigned CW        = 4;
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic        ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_hready, r_hresp;
  logic [31:0]     r_hrdata;
  logic            r_dp_valid, r_dp_write;
  logic [AW-1:0]   r_dp_idx;
  logic [3:0]      r_dp_strb;
  logic [31:0]     r_mem [MEM_DEPTH];

  logic [31:0]     w_offset;
  logic [AW-1:0]   w_idx;
  logic            w_err, w_accept, w_wr_en;
  logic [3:0]      w_strb;
  logic [31:0]     w_fwd_data;
  logic            w_unused;

  // Address-phase decode
  assign w_offset = bus.HADDR - BASE_ADDR;
  assign w_idx    = w_offset[AW+1:2];
  assign w_accept = bus.HSEL & bus.HTRANS[1] & r_hready;
  assign w_err    = (w_offset >= MEM_BYTES)
                  | (bus.HSIZE > 3'd2)
                  | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                  | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
  assign w_wr_en  = r_dp_valid & r_dp_write & r_hready;
  assign w_unused = ^{bus.HTRANS[0], bus.HBURST};

  always_comb begin
    w_strb = 4'b0000;
    case (bus.HSIZE)
      3'd0:    w_strb = 4'(4'b0001 << bus.HADDR[1:0]);
      3'd1:    w_strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
  end

  // Read data for a new address phase, merged with a write completing on the same edge
  always_comb begin
    w_fwd_data = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && (r_dp_idx == w_idx) && r_dp_strb[i])
        w_fwd_data[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (!ZERO_WAIT) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR2);
      r_hresp  <= (w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2);
    end
  end

  // Data-phase context only advances on edges where HREADY is high
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_strb  <= '0;
    end else if (r_hready) begin
      r_dp_valid <= w_accept & ~w_err;
      if (w_accept) begin
        r_dp_write <= bus.HWRITE;
        r_dp_idx   <= w_idx;
        r_dp_strb  <= w_strb;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (ZERO_WAIT && w_accept && !w_err && !bus.HWRITE) begin
      r_hrdata <= w_fwd_data;
    end else if ((r_state == ST_WAIT) && (r_cnt == WAIT_LAST) && !r_dp_write) begin
      r_hrdata <= r_mem[r_dp_idx];
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge HCLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (r_dp_strb[i]) r_mem[r_dp_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADY = r_hready;
  assign bus.HRESP  = r_hresp;
  assign bus.HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one three-wait instance
// share a stimulus driver; dut_sel chooses which one is selected and observed.
`timescale 1ns/1ps
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        d_sel, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_trans;
  logic [2:0]  d_size, d_burst;
  int          dut_sel;

  logic        hready, hresp;
  logic [31:0] hrdata;

  int n_checks = 0;
  int n_errors = 0;

  ahb_sram_slave_if if0();
  ahb_sram_slave_if if3();

  assign if0.HSEL   = d_sel && (dut_sel == 0);
  assign if0.HADDR  = d_addr;
  assign if0.HTRANS = d_trans;
  assign if0.HWRITE = d_write;
  assign if0.HSIZE  = d_size;
  assign if0.HBURST = d_burst;
  assign if0.HWDATA = d_wdata;

  assign if3.HSEL   = d_sel && (dut_sel == 3);
  assign if3.HADDR  = d_addr;
  assign if3.HTRANS = d_trans;
  assign if3.HWRITE = d_write;
  assign if3.HSIZE  = d_size;
  assign if3.HBURST = d_burst;
  assign if3.HWDATA = d_wdata;

  assign hready = (dut_sel == 3) ? if3.HREADY : if0.HREADY;
  assign hresp  = (dut_sel == 3) ? if3.HRESP  : if0.HRESP;
  assign hrdata = (dut_sel == 3) ? if3.HRDATA : if0.HRDATA;

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(if0)
  );

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0000_0000)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .bus(if3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    d_sel = 1'b0; d_trans = 2'b00; d_write = 1'b0;
    d_size = 3'd2; d_burst = 3'd0; d_addr = '0;
  endtask

  // Single transfer; returns at the negedge of the final data-phase cycle
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int nwait, output logic resp_first, output logic resp_last);
    @(negedge clk);
    d_sel = 1'b1; d_trans = 2'b10; d_addr = addr; d_write = wr; d_size = size; d_burst = 3'd0;
    @(negedge clk);
    bus_idle();
    d_wdata    = wdata;
    resp_first = hresp;
    nwait      = 0;
    while (!hready && nwait < 50) begin
      nwait++;
      @(negedge clk);
    end
    if (!hready) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: HREADY still 0 after %0d cycles, expected 1", nwait);
    end
    resp_last = hresp;
    rdata     = hrdata;
  endtask

  task automatic write_ok(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input int exp_wait);
    logic [31:0] rd; int nw; logic r0, r1;
    xfer(1'b1, addr, size, data, rd, nw, r0, r1);
    check_eq({tag, "_wait"}, 32'(nw), 32'(exp_wait));
    check_eq({tag, "_resp"}, {31'd0, r1}, 32'd0);
  endtask

  task automatic read_ok(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp, input int exp_wait);
    logic [31:0] rd; int nw; logic r0, r1;
    xfer(1'b0, addr, 3'd2, 32'h0, rd, nw, r0, r1);
    check_eq({tag, "_wait"}, 32'(nw), 32'(exp_wait));
    check_eq({tag, "_resp"}, {31'd0, r1}, 32'd0);
    check_eq({tag, "_data"}, rd, exp);
  endtask

  task automatic xfer_err(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] held);
    logic [31:0] rd; int nw; logic r0, r1;
    xfer(wr, addr, size, 32'hFFFF_FFFF, rd, nw, r0, r1);
    check_eq({tag, "_wait"},  32'(nw), 32'd1);
    check_eq({tag, "_resp1"}, {31'd0, r0}, 32'd1);
    check_eq({tag, "_resp2"}, {31'd0, r1}, 32'd1);
    check_eq({tag, "_hold"},  rd, held);
  endtask

  logic [31:0] bdata [4];

  // 4-beat INCR word write, pipelined; returns total data-phase cycles
  task automatic burst_write(input logic [31:0] base, output int cycles);
    int beat;
    @(negedge clk);
    d_sel = 1'b1; d_trans = 2'b10; d_addr = base; d_write = 1'b1; d_size = 3'd2; d_burst = 3'b001;
    beat = 0; cycles = 0;
    while (beat < 4 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      d_wdata = bdata[beat];
      if (beat < 3) begin
        d_trans = 2'b11; d_addr = base + 32'((beat + 1) * 4);
      end else begin
        bus_idle();
      end
      if (hready) beat++;
    end
  endtask

  initial begin
    int cyc;
    dut_sel = 0;
    bus_idle();
    d_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst0_hready", {31'd0, if0.HREADY}, 32'd1);
    check_eq("rst0_hresp",  {31'd0, if0.HRESP},  32'd0);
    check_eq("rst0_hrdata", if0.HRDATA, 32'd0);
    check_eq("rst3_hready", {31'd0, if3.HREADY}, 32'd1);
    check_eq("rst3_hrdata", if3.HRDATA, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_hready", {31'd0, hready}, 32'd1);

    // Zero-wait word, byte and halfword accesses
    write_ok("w10", 32'h10, 3'd2, 32'hDEAD_BEEF, 0);
    read_ok ("r10", 32'h10, 32'hDEAD_BEEF, 0);
    write_ok("w20", 32'h20, 3'd2, 32'h1122_3344, 0);
    write_ok("wb22", 32'h22, 3'd0, 32'h0055_0000, 0);
    read_ok ("r20", 32'h20, 32'h1155_3344, 0);
    write_ok("w24", 32'h24, 3'd2, 32'h1111_1111, 0);
    write_ok("wh26", 32'h26, 3'd1, 32'hABCD_0000, 0);
    read_ok ("r24", 32'h24, 32'hABCD_1111, 0);

    // Back-to-back write then read of the same word
    write_ok("w40a", 32'h40, 3'd2, 32'h1234_5678, 0);
    @(negedge clk);
    d_sel = 1'b1; d_trans = 2'b10; d_addr = 32'h40; d_write = 1'b1; d_size = 3'd2;
    @(negedge clk);
    check_eq("b2b_wr_hready", {31'd0, hready}, 32'd1);
    d_wdata = 32'hCAFE_F00D; d_write = 1'b0;
    @(negedge clk);
    bus_idle();
    check_eq("b2b_rd_hready", {31'd0, hready}, 32'd1);
    check_eq("b2b_rd_hresp",  {31'd0, hresp},  32'd0);
    check_eq("b2b_rd_data",   hrdata, 32'hCAFE_F00D);
    read_ok("r40", 32'h40, 32'hCAFE_F00D, 0);

    // Error responses leave memory and HRDATA untouched
    xfer_err("e400", 1'b0, 32'h400, 3'd2, 32'hCAFE_F00D);
    xfer_err("e02",  1'b0, 32'h02,  3'd2, 32'hCAFE_F00D);
    xfer_err("eh11", 1'b1, 32'h11,  3'd1, 32'hCAFE_F00D);
    xfer_err("esz3", 1'b1, 32'h10,  3'd3, 32'hCAFE_F00D);
    read_ok("r10b", 32'h10, 32'hDEAD_BEEF, 0);

    // Three-wait instance
    @(negedge clk);
    dut_sel = 3;
    write_ok("w3_10", 32'h10, 3'd2, 32'hA5A5_A5A5, 3);
    read_ok ("r3_10", 32'h10, 32'hA5A5_A5A5, 3);
    bdata[0] = 32'h1000_0001; bdata[1] = 32'h1000_0002;
    bdata[2] = 32'h1000_0003; bdata[3] = 32'h1000_0004;
    burst_write(32'h100, cyc);
    check_eq("burst_cycles", 32'(cyc), 32'd16);
    read_ok("r3_104", 32'h104, 32'h1000_0002, 3);
    read_ok("r3_10c", 32'h10C, 32'h1000_0004, 3);

    // Reset during the wait cycles of a write aborts it
    write_ok("w3_80", 32'h80, 3'd2, 32'hAAAA_5555, 3);
    read_ok ("r3_10c2", 32'h10C, 32'h1000_0004, 3);
    @(negedge clk);
    d_sel = 1'b1; d_trans = 2'b10; d_addr = 32'h80; d_write = 1'b1; d_size = 3'd2;
    @(negedge clk);
    bus_idle();
    d_wdata = 32'h1234_5678;
    check_eq("wait_hready", {31'd0, hready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_hready", {31'd0, hready}, 32'd1);
    check_eq("arst_hresp",  {31'd0, hresp},  32'd0);
    check_eq("arst_hrdata", hrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_ok("r3_80", 32'h80, 32'hAAAA_5555, 3);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
